// File: rtl/gpi_filter_bank_if.sv
`default_nettype none
// ============================================================================
// Module  : gpi_filter_bank_if
// Brief   : Pad-side inputs, controls and conditioned outputs of the GPI bank.
// Revision: 1.0
// ============================================================================
interface gpi_filter_bank_if #(
    parameter int N_CH   = 8,
    parameter int FILT_W = 4
);
    logic [N_CH-1:0]   PAD_DI_I;
    logic [N_CH-1:0]   IE_I;
    logic [N_CH-1:0]   FILT_EN_I;
    logic [FILT_W-1:0] FILT_LEN_I;
    logic [2*N_CH-1:0] EDGE_SEL_I;
    logic [N_CH-1:0]   EVT_CLR_I;
    logic [N_CH-1:0]   DI_O;
    logic [N_CH-1:0]   EVT_O;
    logic              IRQ_O;

    modport master (
        output PAD_DI_I, IE_I, FILT_EN_I, FILT_LEN_I, EDGE_SEL_I, EVT_CLR_I,
        input  DI_O, EVT_O, IRQ_O
    );

    modport slave (
        input  PAD_DI_I, IE_I, FILT_EN_I, FILT_LEN_I, EDGE_SEL_I, EVT_CLR_I,
        output DI_O, EVT_O, IRQ_O
    );
endinterface
`default_nettype wire

// File: rtl/gpi_filter_bank.sv
`default_nettype none
// ============================================================================
// Module  : gpi_filter_bank
// Brief   : Multi-channel GPI conditioner: gate, synchronise, deglitch,
//           sticky maskable edge events and a combined interrupt.
// Revision: 1.0
// ============================================================================
module gpi_filter_bank #(
    parameter int N_CH        = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_W      = 4
) (
    input  wire logic        CLK_I,
    input  wire logic        RST_NI,
    gpi_filter_bank_if.slave bus
);

    logic [N_CH-1:0]                  w_gated;
    logic [SYNC_STAGES-1:0][N_CH-1:0] sync_q;
    logic [N_CH-1:0]                  w_sync;

    logic [N_CH-1:0]              di_q, di_d;
    logic [N_CH-1:0][FILT_W-1:0]  cnt_q, cnt_d;
    logic [N_CH-1:0]              dly_q;
    logic [N_CH-1:0]              evt_q, evt_d;

    logic [N_CH-1:0] w_rise;
    logic [N_CH-1:0] w_fall;
    logic [N_CH-1:0] w_set;

    // Input enable is re-applied before the first flop so a disabled pad reads 0.
    assign w_gated = bus.PAD_DI_I & bus.IE_I;
    assign w_sync  = sync_q[SYNC_STAGES-1];

    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], w_gated};
        end
    end

    // The >= compare lets a shortened FILT_LEN_I act on the very next edge
    // and keeps the counter from ever reaching a wrap.
    always_comb begin
        di_d  = di_q;
        cnt_d = cnt_q;
        for (int c = 0; c < N_CH; c++) begin
            if (!bus.FILT_EN_I[c]) begin
                di_d[c]  = w_sync[c];
                cnt_d[c] = '0;
            end else if (w_sync[c] == di_q[c]) begin
                cnt_d[c] = '0;
            end else if (cnt_q[c] >= bus.FILT_LEN_I) begin
                di_d[c]  = w_sync[c];
                cnt_d[c] = '0;
            end else begin
                cnt_d[c] = cnt_q[c] + 1'b1;
            end
        end
    end

    assign w_rise = di_q & ~dly_q;
    assign w_fall = ~di_q & dly_q;

    always_comb begin
        w_set = '0;
        for (int c = 0; c < N_CH; c++) begin
            w_set[c] = (w_rise[c] & bus.EDGE_SEL_I[2*c]) |
                       (w_fall[c] & bus.EDGE_SEL_I[2*c+1]);
        end
    end

    // A new edge outranks a clear arriving in the same cycle.
    assign evt_d = w_set | (evt_q & ~bus.EVT_CLR_I);

    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            di_q  <= '0;
            cnt_q <= '0;
            dly_q <= '0;
            evt_q <= '0;
        end else begin
            di_q  <= di_d;
            cnt_q <= cnt_d;
            dly_q <= di_q;
            evt_q <= evt_d;
        end
    end

    assign bus.DI_O  = di_q;
    assign bus.EVT_O = evt_q;
    assign bus.IRQ_O = |evt_q;

endmodule
`default_nettype wire

// File: tb/tb_gpi_filter_bank.sv
`default_nettype none
// ============================================================================
// Module  : tb_gpi_filter_bank
// Brief   : Directed and random checks of gpi_filter_bank against a
//           timestamp-based reference model.
// Revision: 1.0
// ============================================================================
module tb_gpi_filter_bank;
    localparam int N_CH = 8;
    localparam int SYNC = 2;
    localparam int FW   = 4;
    localparam int LOGD = 4096;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gpi_filter_bank_if #(.N_CH(N_CH), .FILT_W(FW)) bus ();

    gpi_filter_bank #(.N_CH(N_CH), .SYNC_STAGES(SYNC), .FILT_W(FW)) dut (
        .CLK_I (clk),
        .RST_NI(rst_n),
        .bus   (bus)
    );

    // Reference model: gated input log indexed by edge number; the filter
    // remembers the last edge at which the channel agreed or updated.
    logic [N_CH-1:0] glog [0:LOGD-1];
    int              n;
    int              t_agree [N_CH];
    logic [N_CH-1:0] m_di, m_dly, m_evt;

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic [N_CH-1:0] s, nd;
        logic            rise, fall, set;
        if (!rst_n) begin
            m_di = '0; m_dly = '0; m_evt = '0; n = 0;
            for (int c = 0; c < N_CH; c++) t_agree[c] = -1;
            return;
        end
        glog[n % LOGD] = bus.PAD_DI_I & bus.IE_I;
        s  = (n >= SYNC) ? glog[(n - SYNC) % LOGD] : '0;
        nd = m_di;
        for (int c = 0; c < N_CH; c++) begin
            if (!bus.FILT_EN_I[c] || s[c] == m_di[c]) begin
                nd[c] = s[c];
                t_agree[c] = n;
            end else if (n - 1 - t_agree[c] >= int'(bus.FILT_LEN_I)) begin
                nd[c] = s[c];
                t_agree[c] = n;
            end
            rise = m_di[c] & ~m_dly[c];
            fall = ~m_di[c] & m_dly[c];
            set  = (rise & bus.EDGE_SEL_I[2*c]) | (fall & bus.EDGE_SEL_I[2*c+1]);
            m_evt[c] = set | (m_evt[c] & ~bus.EVT_CLR_I[c]);
        end
        m_dly = m_di;
        m_di  = nd;
        n++;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("model_di",  32'(bus.DI_O),  32'(m_di));
        chk("model_evt", 32'(bus.EVT_O), 32'(m_evt));
        chk("model_irq", 32'(bus.IRQ_O), 32'(|m_evt));
    endtask

    task automatic settle(input int k);
        repeat (k) step();
    endtask

    task automatic clear_all();
        bus.EVT_CLR_I = '1;
        step();
        bus.EVT_CLR_I = '0;
    endtask

    initial begin
        int lat, hits, first, irq_hi, exp_hits, exp_first;
        logic found, evt_seen;
        logic [1:0] sel;

        bus.PAD_DI_I   = '1;
        bus.IE_I       = '1;
        bus.FILT_EN_I  = '0;
        bus.FILT_LEN_I = '0;
        bus.EDGE_SEL_I = '0;
        bus.EVT_CLR_I  = '0;
        rst_n          = 1'b0;
        settle(3);
        chk("reset_di",  32'(bus.DI_O),  32'h0);
        chk("reset_evt", 32'(bus.EVT_O), 32'h0);
        chk("reset_irq", 32'(bus.IRQ_O), 32'h0);

        rst_n = 1'b1;
        settle(2);
        chk("release_2", 32'(bus.DI_O), 32'h00);
        step();
        chk("release_3", 32'(bus.DI_O), 32'hFF);

        // Filter latency on ch0, L=3 then L=0
        bus.PAD_DI_I = '0; bus.FILT_EN_I = 8'h01; bus.FILT_LEN_I = 4'd3;
        settle(10);
        bus.PAD_DI_I[0] = 1'b1;
        lat = 0; found = 1'b0;
        for (int k = 1; k <= 20 && !found; k++) begin
            step();
            if (bus.DI_O[0]) begin lat = k; found = 1'b1; end
        end
        chk("lat_L3", 32'(lat), 32'd6);
        bus.PAD_DI_I = '0; bus.FILT_LEN_I = 4'd0;
        settle(10);
        bus.PAD_DI_I[0] = 1'b1;
        lat = 0; found = 1'b0;
        for (int k = 1; k <= 20 && !found; k++) begin
            step();
            if (bus.DI_O[0]) begin lat = k; found = 1'b1; end
        end
        chk("lat_L0", 32'(lat), 32'd3);

        // Glitch rejection on ch1, L=3
        bus.PAD_DI_I = '0; bus.FILT_EN_I = '1; bus.FILT_LEN_I = 4'd3;
        bus.EDGE_SEL_I = 16'h000C;
        settle(10);
        clear_all();
        hits = 0; evt_seen = 1'b0;
        for (int r = 1; r <= 15; r++) begin
            bus.PAD_DI_I[1] = (r <= 3);
            step();
            if (bus.DI_O[1]) hits++;
            if (bus.EVT_O[1]) evt_seen = 1'b1;
        end
        chk("glitch3_di",  32'(hits), 32'd0);
        chk("glitch3_evt", 32'(evt_seen), 32'd0);
        hits = 0;
        for (int r = 1; r <= 18; r++) begin
            bus.PAD_DI_I[1] = (r <= 4);
            step();
            if (bus.DI_O[1]) hits++;
        end
        chk("pulse4_di", 32'(hits), 32'd4);

        // Edge select on ch2 with its clear held, so each event shows for one cycle
        bus.FILT_EN_I = '0;
        for (int v = 0; v < 4; v++) begin
            sel = (v == 3) ? 2'b00 : 2'(v + 1);
            bus.EDGE_SEL_I = 16'(sel) << 4;
            bus.PAD_DI_I   = '0;
            clear_all();
            settle(4);
            bus.EVT_CLR_I = 8'h04;
            hits = 0; first = 0; irq_hi = 0;
            for (int r = 1; r <= 14; r++) begin
                bus.PAD_DI_I[2] = (r <= 5);
                step();
                if (bus.EVT_O[2]) begin
                    hits++;
                    if (first == 0) first = r;
                end
                if (bus.IRQ_O) irq_hi++;
            end
            bus.EVT_CLR_I = '0;
            case (sel)
                2'b01:   begin exp_hits = 1; exp_first = 4; end
                2'b10:   begin exp_hits = 1; exp_first = 9; end
                2'b11:   begin exp_hits = 2; exp_first = 4; end
                default: begin exp_hits = 0; exp_first = 0; end
            endcase
            chk($sformatf("edge_sel%0d_hits", sel),  32'(hits),   32'(exp_hits));
            chk($sformatf("edge_sel%0d_first", sel), 32'(first),  32'(exp_first));
            chk($sformatf("edge_sel%0d_irq", sel),   32'(irq_hi), 32'(exp_hits));
        end

        // Set/clear race on ch3
        bus.PAD_DI_I = '0; bus.EDGE_SEL_I = 16'h0040;
        clear_all();
        settle(4);
        bus.PAD_DI_I[3] = 1'b1;
        settle(3);
        chk("race_pre", 32'(bus.EVT_O[3]), 32'd0);
        bus.EVT_CLR_I[3] = 1'b1;
        step();
        chk("race_setwins", 32'(bus.EVT_O[3]), 32'd1);
        step();
        chk("race_cleared", 32'(bus.EVT_O[3]), 32'd0);
        chk("race_irq",     32'(bus.IRQ_O),    32'd0);
        bus.EVT_CLR_I = '0;

        // IE drop on ch4 with L=3
        bus.FILT_EN_I = '1; bus.FILT_LEN_I = 4'd3; bus.EDGE_SEL_I = '0;
        bus.PAD_DI_I = 8'h10; bus.IE_I = '1;
        settle(10);
        chk("ie_pre", 32'(bus.DI_O[4]), 32'd1);
        bus.IE_I[4] = 1'b0;
        settle(5);
        chk("ie_5", 32'(bus.DI_O[4]), 32'd1);
        step();
        chk("ie_6", 32'(bus.DI_O[4]), 32'd0);

        // Shorten filter length mid-count on ch5
        bus.PAD_DI_I = '0; bus.IE_I = '1; bus.FILT_LEN_I = 4'd15;
        settle(20);
        bus.PAD_DI_I[5] = 1'b1;
        settle(7);
        chk("len_drop_pre", 32'(bus.DI_O[5]), 32'd0);
        bus.FILT_LEN_I = 4'd2;
        step();
        chk("len_drop_post", 32'(bus.DI_O[5]), 32'd1);

        // Random traffic against the model
        for (int i = 0; i < 800; i++) begin
            bus.PAD_DI_I = bus.PAD_DI_I ^ N_CH'($urandom & $urandom);
            if ($urandom_range(15) == 0) bus.IE_I = N_CH'($urandom | $urandom);
            if ($urandom_range(31) == 0) bus.FILT_EN_I = N_CH'($urandom);
            if ($urandom_range(19) == 0) bus.FILT_LEN_I = FW'($urandom_range(6));
            if ($urandom_range(31) == 0) bus.EDGE_SEL_I = 16'($urandom);
            bus.EVT_CLR_I = N_CH'($urandom & $urandom & $urandom);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
`default_nettype wire
